reg_arb_mux: RTL and testbench

REG_ARB_MUX -- requirements
Module: reg_arb_mux

---
 rtl/reg_arb_pkg.sv | 38 +++
 rtl/reg_arb_mux_if.sv | 21 ++
 rtl/reg_arb_sel.sv | 32 +++
 rtl/reg_arb_mux.sv | 169 ++++++++++++++++
 tb/tb_reg_arb_mux.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types for the register-interface arbiter/mux: arbitration mode,
// FSM states, default request/response structs and a width helper.
package reg_arb_pkg;

  typedef enum logic {
    ARB_PRIO,
    ARB_RR
  } arb_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP
  } state_e;

  localparam int unsigned DefAw = 32;
  localparam int unsigned DefDw = 32;

  typedef struct packed {
    logic [DefAw-1:0]   addr;
    logic               write;
    logic [DefDw-1:0]   wdata;
    logic [DefDw/8-1:0] wstrb;
    logic               valid;
  } reg_req_t;

  typedef struct packed {
    logic [DefDw-1:0] rdata;
    logic             error;
    logic             ready;
  } reg_rsp_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_arb_mux_if.sv
// Bundle of the arbiter's upstream and downstream register-interface signals.
interface reg_arb_mux_if
  import reg_arb_pkg::*;
#(
  parameter int unsigned NumPorts = 4,
  parameter type         req_t    = reg_req_t,
  parameter type         rsp_t    = reg_rsp_t
);

  req_t in_req  [NumPorts];
  rsp_t in_rsp  [NumPorts];
  req_t out_req;
  rsp_t out_rsp;
  logic busy;
  logic timeout;

  // Upstream requesters drive requests; the downstream target answers them.
  modport master (output in_req, input in_rsp, input busy, input timeout);
  modport slave  (input out_req, output out_rsp);

endinterface

// File: rtl/reg_arb_sel.sv
// Combinational port picker: fixed priority from index 0, or a round-robin
// search that starts at the pointer and wraps.
module reg_arb_sel
  import reg_arb_pkg::*;
#(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned IdxW     = 2
) (
  input  logic [NumPorts-1:0] valid_i,
  input  logic [IdxW-1:0]     ptr_i,
  input  arb_mode_e           mode_i,
  output logic [IdxW-1:0]     idx_o,
  output logic                any_o
);

  int unsigned      base;
  logic [IdxW-1:0]  cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    idx_o = '0;
    any_o = |valid_i;
    base  = (mode_i == ARB_RR) ? 32'(ptr_i) : 32'd0;
    cand  = '0;
    // Walk the ring backwards so the candidate nearest the start point is assigned last and wins.
    for (int k = NumPorts - 1; k >= 0; k--) begin
      cand = IdxW'((base + 32'(k)) % NumPorts);
      if (valid_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/reg_arb_mux.sv
// N-to-1 register-interface arbiter: grants one upstream port, forwards its
// request through registers, and returns the downstream response (or a timeout).
module reg_arb_mux
  import reg_arb_pkg::*;
#(
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter arb_mode_e   ArbMode       = ARB_RR,
  parameter int unsigned TimeoutCycles = 0,
  parameter type         req_t         = reg_req_t,
  parameter type         rsp_t         = reg_rsp_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  req_t in_req_i  [NumPorts],
  output rsp_t in_rsp_o  [NumPorts],
  output req_t out_req_o,
  input  rsp_t out_rsp_i,
  output logic busy_o,
  output logic timeout_o
);

  localparam int unsigned IdxW = min1_clog2(NumPorts);
  localparam int unsigned CntW = min1_clog2(TimeoutCycles + 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d, ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                write_q, write_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW/8-1:0]     wstrb_q, wstrb_d;
  logic                valid_q, valid_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                error_q, error_d;
  logic                timeout_q, timeout_d;

  logic [NumPorts-1:0] valid_vec;
  logic [IdxW-1:0]     grant_idx;
  logic                any_valid;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NumPorts; i++) valid_vec[i] = in_req_i[i].valid;
  end

  reg_arb_sel #(
    .NumPorts (NumPorts),
    .IdxW     (IdxW)
  ) u_sel (
    .valid_i (valid_vec),
    .ptr_i   (ptr_q),
    .mode_i  (ArbMode),
    .idx_o   (grant_idx),
    .any_o   (any_valid)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    valid_d   = 1'b0;
    rdata_d   = rdata_q;
    error_d   = error_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d = ST_REQ;
          idx_d   = grant_idx;
          addr_d  = in_req_i[grant_idx].addr;
          write_d = in_req_i[grant_idx].write;
          wdata_d = in_req_i[grant_idx].wdata;
          wstrb_d = in_req_i[grant_idx].wstrb;
          cnt_d   = '0;
          valid_d = 1'b1;
        end
      end
      ST_REQ: begin
        valid_d = 1'b1;
        // Ready is checked first so it beats a timeout landing in the same cycle.
        if (out_rsp_i.ready) begin
          rdata_d = out_rsp_i.rdata;
          error_d = out_rsp_i.error;
          valid_d = 1'b0;
          state_d = ST_RSP;
        end else if (TimeoutCycles != 0) begin
          cnt_d = cnt_q + CntW'(1);
          if (32'(cnt_q) + 32'd1 == TimeoutCycles) begin
            rdata_d   = '0;
            error_d   = 1'b1;
            timeout_d = 1'b1;
            valid_d   = 1'b0;
            state_d   = ST_RSP;
          end
        end
      end
      ST_RSP: begin
        state_d = ST_IDLE;
        if (ArbMode == ARB_RR) begin
          ptr_d = (32'(idx_q) == NumPorts - 1) ? '0 : idx_q + IdxW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      valid_q   <= valid_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    out_req_o       = '0;
    out_req_o.addr  = addr_q;
    out_req_o.write = write_q;
    out_req_o.wdata = wdata_q;
    out_req_o.wstrb = wstrb_q;
    out_req_o.valid = valid_q;
  end

  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      in_rsp_o[i] = '0;
      if (state_q == ST_RSP && idx_q == IdxW'(i)) begin
        in_rsp_o[i].ready = 1'b1;
        in_rsp_o[i].rdata = rdata_q;
        in_rsp_o[i].error = error_q;
      end
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_reg_arb_mux.sv
// Bench for reg_arb_mux: a round-robin/timeout instance and a fixed-priority
// instance share stimulus; a transaction-level model predicts each cycle.
module tb_reg_arb_mux;
  import reg_arb_pkg::*;

  localparam int NP   = 4;
  localparam int TO_A = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_req_t up_req [NP];
  reg_rsp_t dn_rsp;
  bit       sel;

  reg_arb_mux_if #(.NumPorts(NP)) bus_a ();
  reg_arb_mux_if #(.NumPorts(NP)) bus_b ();

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      bus_a.in_req[i] = up_req[i];
      bus_b.in_req[i] = up_req[i];
    end
    bus_a.out_rsp = dn_rsp;
    bus_b.out_rsp = dn_rsp;
  end

  reg_arb_mux #(.NumPorts(NP), .ArbMode(ARB_RR), .TimeoutCycles(TO_A)) dut_a (
    .clk_i     (clk),
    .rst_i     (rst),
    .in_req_i  (bus_a.in_req),
    .in_rsp_o  (bus_a.in_rsp),
    .out_req_o (bus_a.out_req),
    .out_rsp_i (bus_a.out_rsp),
    .busy_o    (bus_a.busy),
    .timeout_o (bus_a.timeout)
  );

  reg_arb_mux #(.NumPorts(NP), .ArbMode(ARB_PRIO), .TimeoutCycles(0)) dut_b (
    .clk_i     (clk),
    .rst_i     (rst),
    .in_req_i  (bus_b.in_req),
    .in_rsp_o  (bus_b.in_rsp),
    .out_req_o (bus_b.out_req),
    .out_rsp_i (bus_b.out_rsp),
    .busy_o    (bus_b.busy),
    .timeout_o (bus_b.timeout)
  );

  reg_req_t obs_req;
  reg_rsp_t obs_rsp [NP];
  logic     obs_busy, obs_to;

  always_comb begin
    obs_req  = sel ? bus_b.out_req : bus_a.out_req;
    obs_busy = sel ? bus_b.busy    : bus_a.busy;
    obs_to   = sel ? bus_b.timeout : bus_a.timeout;
    for (int i = 0; i < NP; i++) obs_rsp[i] = sel ? bus_b.in_rsp[i] : bus_a.in_rsp[i];
  end

  // Reference model state: round-robin start point, mode and timeout of the instance under test.
  int ptr;
  bit cur_rr;
  int cur_to;

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NP-1:0] mask);
    for (int k = 0; k < NP; k++) begin
      int j;
      j = cur_rr ? (ptr + k) % NP : k;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  task automatic check_ports(input string tag, input int w, input logic [31:0] rd, input logic er);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s_p%0d_ready", tag, i), obs_rsp[i].ready, (i == w));
      check($sformatf("%s_p%0d_rdata", tag, i), obs_rsp[i].rdata, (i == w) ? rd : 32'h0);
      check($sformatf("%s_p%0d_error", tag, i), obs_rsp[i].error, (i == w) ? er : 1'b0);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, obs_busy, 1'b0);
    check({tag, "_out_valid"}, obs_req.valid, 1'b0);
    check({tag, "_timeout"}, obs_to, 1'b0);
    check_ports(tag, -1, 32'h0, 1'b0);
  endtask

  // Entered and left at #1 after a rising edge with the DUT expected idle.
  // d = number of REQ cycles with ready low before ready is raised.
  task automatic run_txn(input logic [NP-1:0] mask, input int d, input bit drop, input bit fixed);
    int          w;
    int          n;
    bit          done;
    bit          to_hit;
    reg_req_t    pl;
    logic [31:0] exp_rd;
    logic        exp_er;

    check_idle("idle");
    for (int i = 0; i < NP; i++) begin
      up_req[i].addr  = fixed ? 32'h10 : $urandom;
      up_req[i].write = fixed ? 1'b0 : 1'($urandom_range(0, 1));
      up_req[i].wdata = $urandom;
      up_req[i].wstrb = 4'($urandom);
      up_req[i].valid = mask[i];
    end
    dn_rsp.rdata = $urandom;
    dn_rsp.error = 1'($urandom_range(0, 1));
    dn_rsp.ready = 1'b0;

    w = pick(mask);
    if (w < 0) begin
      @(posedge clk); #1;
      return;
    end
    pl     = up_req[w];
    n      = 0;
    done   = 1'b0;
    to_hit = 1'b0;
    exp_rd = '0;
    exp_er = 1'b0;

    while (!done) begin
      @(posedge clk); #1;
      n++;
      check("req_valid", obs_req.valid, 1'b1);
      check("req_addr", obs_req.addr, pl.addr);
      check("req_write", obs_req.write, pl.write);
      check("req_wdata", obs_req.wdata, pl.wdata);
      check("req_wstrb", obs_req.wstrb, pl.wstrb);
      check("req_busy", obs_busy, 1'b1);
      check("req_timeout", obs_to, 1'b0);
      check_ports("req", -1, 32'h0, 1'b0);
      if (drop && n == 1) up_req[w].valid = 1'b0;
      dn_rsp.rdata = fixed ? 32'hDEADBEEF : $urandom;
      dn_rsp.error = fixed ? 1'b0 : 1'($urandom_range(0, 1));
      dn_rsp.ready = (n - 1 == d);
      if (n - 1 == d) begin
        done   = 1'b1;
        exp_rd = dn_rsp.rdata;
        exp_er = dn_rsp.error;
      end else if (cur_to > 0 && n == cur_to) begin
        done   = 1'b1;
        to_hit = 1'b1;
        exp_rd = '0;
        exp_er = 1'b1;
      end
    end

    @(posedge clk); #1;
    dn_rsp.ready = 1'b0;
    dn_rsp.rdata = $urandom;
    check("rsp_out_valid", obs_req.valid, 1'b0);
    check("rsp_busy", obs_busy, 1'b1);
    check("rsp_timeout", obs_to, to_hit);
    check_ports("rsp", w, exp_rd, exp_er);
    if (cur_rr) ptr = (w + 1) % NP;

    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    sel    = 1'b0;
    cur_rr = 1'b1;
    cur_to = TO_A;
    ptr    = 0;
    rst    = 1'b1;
    for (int i = 0; i < NP; i++) up_req[i] = '0;
    dn_rsp = '0;

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_out_req", obs_req, '0);
    rst = 1'b0;

    // Continuous requests on every port rotate 0,1,2,3,0 at three cycles each.
    repeat (5) run_txn(4'hF, 0, 1'b0, 1'b0);
    // Directed read with a known downstream word.
    run_txn(4'b0001, 0, 1'b0, 1'b1);
    // Downstream never answers: abort after TO_A cycles.
    run_txn(4'b0100, 20, 1'b0, 1'b0);
    // Ready on the last permitted wait cycle completes normally.
    run_txn(4'b0010, TO_A - 1, 1'b0, 1'b0);

    repeat (60) run_txn(4'($urandom), $urandom_range(0, 10), ($urandom_range(0, 5) == 0), 1'b0);

    // Park the pointer away from 0, then reset in the middle of a request.
    run_txn(4'b0010, 0, 1'b0, 1'b0);
    for (int i = 0; i < NP; i++) up_req[i].valid = (i == 2);
    @(posedge clk); #1;
    check("rstreq_valid", obs_req.valid, 1'b1);
    rst          = 1'b1;
    dn_rsp.ready = 1'b1;
    for (int i = 0; i < NP; i++) up_req[i].valid = 1'b0;
    @(posedge clk); #1;
    check_idle("rst_in_req");
    rst          = 1'b0;
    dn_rsp.ready = 1'b0;
    ptr          = 0;
    @(posedge clk); #1;
    run_txn(4'hF, 0, 1'b0, 1'b0);

    // Switch to the fixed-priority instance without a timeout.
    rst    = 1'b1;
    sel    = 1'b1;
    cur_rr = 1'b0;
    cur_to = 0;
    ptr    = 0;
    for (int i = 0; i < NP; i++) up_req[i].valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("prio_reset");
    rst = 1'b0;

    run_txn(4'b1010, 1, 1'b0, 1'b0);
    run_txn(4'b1000, 1, 1'b0, 1'b0);
    repeat (60) run_txn(4'($urandom), $urandom_range(0, 12), ($urandom_range(0, 5) == 0), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
